icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the memory hierarchy.
- Services one whole-line lookup per cycle from the fetch PC. A hit returns the line in the same cycle.
- On a miss, issues a single line-fill request, blocks (icache_ready low) until the fill returns, installs the line, then accepts requests again.

Parameters:
- PC_WIDTH, 32, request address width in bits (byte address).
- LINE_WIDTH, 128, cache line width in bits (4 x 32-bit instructions).
- NUM_LINES, 4, number of direct-mapped lines; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- icache_ready  out  1  high when idle and able to accept a lookup.
- req_valid  in  1  lookup request; only honoured when icache_ready is high.
- req_addr  in  PC_WIDTH  byte address of the instruction being fetched.
- rsp_valid  out  1  combinational hit indication for the current request.
- rsp_data  out  LINE_WIDTH  full cached line for the current request.
- req_info_miss  out  memory_request_t  fill request. Fields: addr (PC_WIDTH, line-aligned), is_store (always 0), data (LINE_WIDTH, always 0).
- req_valid_miss  out  1  one-cycle strobe qualifying req_info_miss.
- rsp_data_miss  in  LINE_WIDTH  fill data returned by memory.
- rsp_valid_miss  in  1  fill data valid strobe.

Behaviour:
- Address split:
  - offset = low log2(LINE_WIDTH/8) bits (4 by default), ignored by the cache.
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, LINE_WIDTH data. Valid bits are flops cleared by reset; data and tag arrays need no reset.
- States: IDLE, MISS_REQ, MISS_WAIT.
- IDLE:
  - icache_ready = 1.
  - Hit = req_valid & valid[index] & (tag match).
  - rsp_valid = hit, combinational in the same cycle. rsp_data = data[index] whenever valid[index], else 0.
  - On req_valid and not hit: latch the line-aligned address (offset bits zeroed), go to MISS_REQ.
  - req_valid low: rsp_valid = 0, stay in IDLE.
- MISS_REQ:
  - icache_ready = 0, rsp_valid = 0.
  - req_valid_miss = 1 for exactly this cycle; req_info_miss.addr = latched address.
  - Unconditionally go to MISS_WAIT next cycle.
- MISS_WAIT:
  - icache_ready = 0, rsp_valid = 0, req_valid_miss = 0.
  - On rsp_valid_miss: write rsp_data_miss into data[latched index], write the latched tag, set valid, go to IDLE.
- Latency:
  - Hit: 0 cycles.
  - Miss: request strobe 1 cycle after the miss cycle; line usable the cycle after rsp_valid_miss. The requester re-presents the address, which then hits.
- rsp_valid_miss outside MISS_WAIT is ignored; no state or array change.
- req_valid while icache_ready = 0 is ignored.
- req_info_miss holds the latched value outside MISS_REQ; only the strobe qualifies it.
- A fill to an index holding a different valid tag overwrites it (no write-back, read-only).
- Reset asserted:
  - All valid bits cleared, state = IDLE.
  - Outputs: rsp_valid = 0, req_valid_miss = 0, req_info_miss = 0, icache_ready = 1 after release.
  - Reset during MISS_REQ or MISS_WAIT abandons the miss; a later rsp_valid_miss is ignored.
- Only one outstanding miss at any time; no prefetch.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req_valid=1, req_addr=0x0000_1004.
  - Same cycle: rsp_valid=0. Next cycle: icache_ready=0, req_valid_miss=1, req_info_miss.addr=0x0000_1000, is_store=0.
  - Following cycle: req_valid_miss=0.
- Fill then hit:
  - Stimulus: in MISS_WAIT drive rsp_valid_miss=1, rsp_data_miss=0x44444444_33333333_22222222_11111111.
  - Next cycle: icache_ready=1. req_addr=0x0000_100C gives rsp_valid=1 and rsp_data equal to that line in the same cycle.
- Conflict eviction:
  - Stimulus: fill 0x0000_1000 (index 0), then request 0x0000_2000 (same index, new tag).
  - Required: miss, req_info_miss.addr=0x0000_2000. After fill, 0x0000_1000 misses again.
- Distinct indexes:
  - Stimulus: fill 0x0, 0x10, 0x20, 0x30.
  - Required: all four then hit back-to-back, rsp_valid=1 each cycle, no req_valid_miss.
- Stray fill and blocked requests:
  - Stimulus: rsp_valid_miss=1 in IDLE with empty cache.
  - Required: next lookup of any address still misses.
  - Stimulus: req_valid toggled during MISS_WAIT.
  - Required: no second req_valid_miss.
- Reset mid-miss:
  - Stimulus: assert reset in MISS_WAIT, release, then rsp_valid_miss=1.
  - Required: icache_ready=1, the original address still misses, and a fresh req_valid_miss is issued.

Source files
------------

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped, read-only instruction cache. Serves one whole-line
//            lookup per cycle with a same-cycle hit response. On a miss it
//            issues one line-fill request, blocks until the fill returns,
//            installs the line, and then accepts lookups again.
// Ports    : clock          - system clock, rising-edge active
//            reset          - asynchronous active-low reset
//            icache_ready   - idle and able to accept a lookup
//            req_valid      - lookup request (honoured only when ready)
//            req_addr       - byte address of the fetched instruction
//            rsp_valid      - combinational hit for the current request
//            rsp_data       - cached line at the request index (0 if invalid)
//            req_info_miss  - fill request, packed as {addr, is_store, data}
//            req_valid_miss - one-cycle strobe qualifying req_info_miss
//            rsp_data_miss  - fill data from memory
//            rsp_valid_miss - fill data valid strobe
// Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
    parameter int PC_WIDTH   = 32,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_LINES  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic                           icache_ready,
    input  logic                           req_valid,
    input  logic [PC_WIDTH-1:0]            req_addr,
    output logic                           rsp_valid,
    output logic [LINE_WIDTH-1:0]          rsp_data,
    output logic [PC_WIDTH+LINE_WIDTH:0]   req_info_miss,
    output logic                           req_valid_miss,
    input  logic [LINE_WIDTH-1:0]          rsp_data_miss,
    input  logic                           rsp_valid_miss
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = PC_WIDTH - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic                   req_valid_miss_q;
    logic [PC_WIDTH-1:0]    addr_q;          // line-aligned miss address
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
    logic [LINE_WIDTH-1:0]  data_q [NUM_LINES];

    logic [INDEX_BITS-1:0]  lookup_idx;
    logic [TAG_BITS-1:0]    lookup_tag;
    logic                   lookup_line_valid;
    logic                   lookup_hit;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   fill_accept;
    logic                   unused_offset_bits;

    // Byte offset within a line never affects a whole-line lookup.
    assign unused_offset_bits = ^req_addr[OFFSET_BITS-1:0];

    assign lookup_idx        = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign lookup_tag        = req_addr[PC_WIDTH-1 -: TAG_BITS];
    assign lookup_line_valid = valid_q[lookup_idx];

    // Hits are only possible while idle; in the miss states the cache is busy.
    assign lookup_hit = (state_q == IDLE) && req_valid && lookup_line_valid &&
                        (tag_q[lookup_idx] == lookup_tag);

    assign fill_idx    = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign fill_tag    = addr_q[PC_WIDTH-1 -: TAG_BITS];
    assign fill_accept = (state_q == MISS_WAIT) && rsp_valid_miss;

    assign icache_ready   = ready_q;
    assign rsp_valid      = lookup_hit;
    assign rsp_data       = lookup_line_valid ? data_q[lookup_idx] : '0;
    assign req_valid_miss = req_valid_miss_q;
    // Read-only cache: is_store and write data are always zero.
    assign req_info_miss  = {addr_q, 1'b0, {LINE_WIDTH{1'b0}}};

    // Control FSM with registered ready / strobe outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            ready_q          <= 1'b1;
            req_valid_miss_q <= 1'b0;
            addr_q           <= '0;
            valid_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !lookup_hit) begin
                        addr_q           <= {req_addr[PC_WIDTH-1:OFFSET_BITS],
                                             {OFFSET_BITS{1'b0}}};
                        ready_q          <= 1'b0;
                        req_valid_miss_q <= 1'b1;
                        state_q          <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    req_valid_miss_q <= 1'b0;
                    state_q          <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (rsp_valid_miss) begin
                        valid_q[fill_idx] <= 1'b1;
                        ready_q           <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: begin
                    ready_q          <= 1'b1;
                    req_valid_miss_q <= 1'b0;
                    state_q          <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; their contents are only observed
    // through a set valid bit.
    always_ff @(posedge clock) begin
        if (fill_accept) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= rsp_data_miss;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_dm
// Purpose  : Directed self-checking bench for icache_dm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

    logic         clock;
    logic         reset;
    logic         icache_ready;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic [160:0] req_info_miss;
    logic         req_valid_miss;
    logic [127:0] rsp_data_miss;
    logic         rsp_valid_miss;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_B = 128'hBBBBBBBB_BBBBBBBB_22220000_00002222;
    localparam logic [127:0] LINE_0 = 128'h00000000_00000000_00000000_0000A000;
    localparam logic [127:0] LINE_1 = 128'h11111111_00000000_00000000_0000A001;
    localparam logic [127:0] LINE_2 = 128'h22222222_00000000_00000000_0000A002;
    localparam logic [127:0] LINE_3 = 128'h33333333_00000000_00000000_0000A003;
    localparam logic [127:0] LINE_S = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] LINE_C = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;

    icache_dm #(
        .PC_WIDTH   (32),
        .LINE_WIDTH (128),
        .NUM_LINES  (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .icache_ready   (icache_ready),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .req_info_miss  (req_info_miss),
        .req_valid_miss (req_valid_miss),
        .rsp_data_miss  (rsp_data_miss),
        .rsp_valid_miss (rsp_valid_miss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full miss/fill sequence starting from IDLE. Checks the same-cycle miss,
    // the request strobe and address, the strobe dropping, and ready returning.
    task automatic miss_fill(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_line, input logic [127:0] line);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        check({tag, "_miss_rsp"}, rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        #1;
        check({tag, "_ready_lo"}, icache_ready, 0);
        check({tag, "_strobe"}, req_valid_miss, 1);
        check({tag, "_req_addr"}, req_info_miss[160:129], exp_line);
        check({tag, "_is_store"}, req_info_miss[128], 0);
        tick();
        #1;
        check({tag, "_strobe_lo"}, req_valid_miss, 0);
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = line;
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        #1;
        check({tag, "_ready_hi"}, icache_ready, 1);
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] addr, input logic [127:0] line);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        check({tag, "_hit"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, line);
        check({tag, "_no_strobe"}, req_valid_miss, 0);
    endtask

    initial begin
        reset          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = '0;
        rsp_data_miss  = '0;
        rsp_valid_miss = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_strobe", req_valid_miss, 0);
        check("rst_info", req_info_miss, 0);
        reset = 1'b1;
        tick();
        check("rst_ready", icache_ready, 1);

        // Cold miss, fill, then hit on a different offset of the same line
        miss_fill("cold", 32'h0000_1004, 32'h0000_1000, LINE_A);
        expect_hit("hit_100c", 32'h0000_100C, LINE_A);
        tick();
        req_valid = 1'b0;

        // Conflict eviction on index 0
        miss_fill("conflict", 32'h0000_2000, 32'h0000_2000, LINE_B);
        expect_hit("hit_2000", 32'h0000_2008, LINE_B);
        tick();
        req_valid = 1'b0;
        miss_fill("evicted", 32'h0000_1000, 32'h0000_1000, LINE_A);

        // Distinct indexes, then back-to-back hits
        miss_fill("fill_00", 32'h0000_0000, 32'h0000_0000, LINE_0);
        miss_fill("fill_10", 32'h0000_0014, 32'h0000_0010, LINE_1);
        miss_fill("fill_20", 32'h0000_0028, 32'h0000_0020, LINE_2);
        miss_fill("fill_30", 32'h0000_003C, 32'h0000_0030, LINE_3);
        expect_hit("b2b_00", 32'h0000_0000, LINE_0);
        tick();
        expect_hit("b2b_10", 32'h0000_0010, LINE_1);
        tick();
        expect_hit("b2b_20", 32'h0000_0020, LINE_2);
        tick();
        expect_hit("b2b_30", 32'h0000_0030, LINE_3);
        tick();
        req_valid = 1'b0;
        #1;
        check("b2b_ready", icache_ready, 1);
        check("b2b_no_strobe", req_valid_miss, 0);

        // Stray fill into an empty cache is ignored
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = LINE_S;
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        #1;
        check("stray_ready", icache_ready, 1);
        miss_fill("after_stray", 32'h0000_0000, 32'h0000_0000, LINE_0);

        // Requests while blocked do not trigger another fill request
        req_valid = 1'b1;
        req_addr  = 32'h0000_0050;
        tick();
        req_valid = 1'b0;
        #1;
        check("blk_strobe", req_valid_miss, 1);
        check("blk_addr", req_info_miss[160:129], 32'h0000_0050);
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h0000_0090;
        #1;
        check("blk_rsp_valid", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        #1;
        check("blk_no_strobe1", req_valid_miss, 0);
        check("blk_ready_lo", icache_ready, 0);
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        #1;
        check("blk_no_strobe2", req_valid_miss, 0);
        check("blk_held_addr", req_info_miss[160:129], 32'h0000_0050);
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = LINE_1;
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        #1;
        check("blk_ready_hi", icache_ready, 1);
        expect_hit("blk_hit_50", 32'h0000_0054, LINE_1);
        tick();
        req_valid = 1'b0;

        // Reset during MISS_WAIT abandons the miss
        req_valid = 1'b1;
        req_addr  = 32'h0000_0070;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_strobe", req_valid_miss, 0);
        check("mid_rst_info", req_info_miss, 0);
        tick();
        reset = 1'b1;
        tick();
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = LINE_C;
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        #1;
        check("mid_rst_ready", icache_ready, 1);
        miss_fill("refetch_70", 32'h0000_0070, 32'h0000_0070, LINE_C);
        expect_hit("hit_70", 32'h0000_0070, LINE_C);
        tick();
        req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
